// File: rtl/pu_or1k_pipeline_sequencer_pkg.sv
// pu_or1k_seq_pkg: shared state encoding and flush counter width for the pipeline sequencer
package pu_or1k_seq_pkg;
  typedef enum logic [1:0] {SEQ_RUN, SEQ_FLUSH, SEQ_REFILL, SEQ_HALT} seq_state_t;
  localparam int SEQ_FLUSH_CNT_WIDTH = 4;
endpackage

// File: rtl/pu_or1k_pipeline_sequencer_if.sv
// pu_or1k_pipeline_sequencer_if: stage status in, advance/flush/debug controls out
interface pu_or1k_pipeline_sequencer_if #(parameter int OPTION_OPERAND_WIDTH = 32);
  logic fetch_valid_i;
  logic decode_valid_i;
  logic execute_valid_i;
  logic ctrl_valid_i;
  logic ctrl_exception_i;
  logic ctrl_op_rfe_i;
  logic fetch_redirect_ack_i;
  logic du_stall_i;
  logic padv_fetch_o;
  logic padv_decode_o;
  logic padv_execute_o;
  logic padv_ctrl_o;
  logic pipeline_flush_o;
  logic du_stalled_o;
  logic [1:0] seq_state_o;
  logic [OPTION_OPERAND_WIDTH-1:0] stall_cnt_o;
  modport master (
    output fetch_valid_i, decode_valid_i, execute_valid_i, ctrl_valid_i,
           ctrl_exception_i, ctrl_op_rfe_i, fetch_redirect_ack_i, du_stall_i,
    input  padv_fetch_o, padv_decode_o, padv_execute_o, padv_ctrl_o,
           pipeline_flush_o, du_stalled_o, seq_state_o, stall_cnt_o
  );
  modport slave (
    input  fetch_valid_i, decode_valid_i, execute_valid_i, ctrl_valid_i,
           ctrl_exception_i, ctrl_op_rfe_i, fetch_redirect_ack_i, du_stall_i,
    output padv_fetch_o, padv_decode_o, padv_execute_o, padv_ctrl_o,
           pipeline_flush_o, du_stalled_o, seq_state_o, stall_cnt_o
  );
endinterface

// File: rtl/pu_or1k_pipeline_sequencer_perf_counter.sv
// pu_or1k_seq_perf_counter: saturating up-counter with enable and synchronous clear
module pu_or1k_seq_perf_counter #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (en && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pu_or1k_pipeline_sequencer.sv
// pu_or1k_pipeline_sequencer: padv strobes, multi-cycle flush and debug halt sequencing
// Define PU_OR1K_SEQ_PERF_EN to count RUN cycles where execute does not advance.
module pu_or1k_pipeline_sequencer
  import pu_or1k_seq_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int OPTION_OPERAND_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  pu_or1k_pipeline_sequencer_if.slave bus
);
  localparam logic [SEQ_FLUSH_CNT_WIDTH-1:0] FLUSH_LOAD = SEQ_FLUSH_CNT_WIDTH'(FLUSH_CYCLES - 1);
  seq_state_t state_q, state_d;
  logic [SEQ_FLUSH_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic flush_q, stalled_q, run, adv, flush_req;
  logic [OPTION_OPERAND_WIDTH-1:0] stall_cnt;
  assign run = !rst && state_q == SEQ_RUN;
  assign adv = bus.fetch_valid_i & bus.decode_valid_i & bus.execute_valid_i;
  assign flush_req = bus.ctrl_valid_i & (bus.ctrl_exception_i | bus.ctrl_op_rfe_i);
  // Exceptions and debug stalls are only sampled in RUN; elsewhere they wait.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
    unique case (state_q)
      SEQ_RUN: begin
        state_d = flush_req ? SEQ_FLUSH : (bus.ctrl_valid_i && bus.du_stall_i) ? SEQ_HALT : SEQ_RUN;
        cnt_d = flush_req ? FLUSH_LOAD : cnt_q;
      end
      SEQ_FLUSH:  state_d = cnt_q == '0 ? SEQ_REFILL : SEQ_FLUSH;
      SEQ_REFILL: state_d = bus.fetch_redirect_ack_i ? SEQ_RUN : SEQ_REFILL;
      default:    state_d = bus.du_stall_i ? SEQ_HALT : SEQ_RUN;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= SEQ_RUN;
      cnt_q <= '0;
      flush_q <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      flush_q <= state_d == SEQ_FLUSH;
      stalled_q <= state_d == SEQ_HALT;
    end
`ifdef PU_OR1K_SEQ_PERF_EN
  pu_or1k_seq_perf_counter #(.W(OPTION_OPERAND_WIDTH)) u_perf (
    .clk(clk),
    .rst(rst),
    .en(run && !adv),
    .cnt(stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif
  assign bus.padv_fetch_o = run & adv;
  assign bus.padv_decode_o = run & adv;
  assign bus.padv_execute_o = run & adv;
  assign bus.padv_ctrl_o = run & bus.ctrl_valid_i;
  assign bus.pipeline_flush_o = flush_q;
  assign bus.du_stalled_o = stalled_q;
  assign bus.seq_state_o = state_q;
  assign bus.stall_cnt_o = stall_cnt;
endmodule

// File: tb/tb_pu_or1k_pipeline_sequencer.sv
// tb_pu_or1k_pipeline_sequencer: vector table through a scoreboard queue, one row per cycle
module tb_pu_or1k_pipeline_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  pu_or1k_pipeline_sequencer_if bus ();
  pu_or1k_pipeline_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  // in = {rst, fetch_v, decode_v, execute_v, ctrl_v, exception, rfe, ack, du_stall}
  // o  = {padv_fetch/decode/execute, padv_ctrl, pipeline_flush, du_stalled}
  typedef struct {
    logic [8:0] in;
    logic [3:0] o;
    logic [1:0] s;
    int c;
  } vec_t;
  localparam logic [8:0] R = 9'b100000000, A = 9'b011110000, EV = 9'b000100000, CV = 9'b000010000;
  localparam logic [8:0] EX = 9'b000001000, RF = 9'b000000100, AK = 9'b000000010, DS = 9'b000000001;
  vec_t tbl[$];
  vec_t sb[$];
  int compared = 0, mismatched = 0;
  task automatic add(input logic [8:0] in, input logic [3:0] o, input logic [1:0] s, input int c);
    vec_t v;
    v.in = in;
    v.o = o;
    v.s = s;
    v.c = c;
    tbl.push_back(v);
  endtask
  task automatic check(input string nm, input int row, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL row %0d %s: got %0h, expected %0h", row, nm, got, want);
    end
  endtask
  initial begin
    vec_t v, e;
    int want_cnt;
    add(A | R, 4'b0000, 0, 0);
    for (int i = 0; i < 10; i++) add(A, 4'b1100, 0, 0);
    add(A & ~EV, 4'b0100, 0, 0);
    add(A & ~EV, 4'b0100, 0, 1);
    add(A & ~EV, 4'b0100, 0, 2);
    add(A, 4'b1100, 0, 3);
    add(A | EX, 4'b1100, 0, 3);
    add(A, 4'b0010, 1, 3);
    add(A, 4'b0010, 1, 3);
    add(A, 4'b0000, 2, 3);
    add(A | AK, 4'b0000, 2, 3);
    add(A, 4'b1100, 0, 3);
    add(A | EX, 4'b1100, 0, 3);
    add(A | AK, 4'b0010, 1, 3);
    add(A | AK, 4'b0010, 1, 3);
    add(A, 4'b0000, 2, 3);
    add(A, 4'b0000, 2, 3);
    add(A | AK, 4'b0000, 2, 3);
    add(A, 4'b1100, 0, 3);
    add(A | RF, 4'b1100, 0, 3);
    add(A, 4'b0010, 1, 3);
    add(A, 4'b0010, 1, 3);
    add(A | AK, 4'b0000, 2, 3);
    add(A, 4'b1100, 0, 3);
    add((A & ~CV) | EX | DS, 4'b1000, 0, 3);
    add(A, 4'b1100, 0, 3);
    add(A | EX | DS, 4'b1100, 0, 3);
    add(A | DS, 4'b0010, 1, 3);
    add(A | DS, 4'b0010, 1, 3);
    add(A | DS | AK, 4'b0000, 2, 3);
    add(A | DS, 4'b1100, 0, 3);
    add(A | DS, 4'b0001, 3, 3);
    add(A | EX, 4'b0001, 3, 3);
    add(A, 4'b1100, 0, 3);
    add(A, 4'b1100, 0, 3);
    add(A | EX, 4'b1100, 0, 3);
    add(A, 4'b0010, 1, 3);
    add(A | R, 4'b0010, 1, 3);
    add(A, 4'b1100, 0, 0);
    add(A, 4'b1100, 0, 0);
    add(A & ~EV, 4'b0100, 0, 0);
    add(A, 4'b1100, 0, 1);
    rst = 1'b1;
    {bus.fetch_valid_i, bus.decode_valid_i, bus.execute_valid_i, bus.ctrl_valid_i,
     bus.ctrl_exception_i, bus.ctrl_op_rfe_i, bus.fetch_redirect_ack_i, bus.du_stall_i} = '0;
    @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      v = tbl[i];
      {rst, bus.fetch_valid_i, bus.decode_valid_i, bus.execute_valid_i, bus.ctrl_valid_i,
       bus.ctrl_exception_i, bus.ctrl_op_rfe_i, bus.fetch_redirect_ack_i, bus.du_stall_i} = v.in;
      sb.push_back(v);
      #1;
      e = sb.pop_front();
`ifdef PU_OR1K_SEQ_PERF_EN
      want_cnt = e.c;
`else
      want_cnt = 0;
`endif
      check("padv_fetch", i, 32'(bus.padv_fetch_o), 32'(e.o[3]));
      check("padv_decode", i, 32'(bus.padv_decode_o), 32'(e.o[3]));
      check("padv_execute", i, 32'(bus.padv_execute_o), 32'(e.o[3]));
      check("padv_ctrl", i, 32'(bus.padv_ctrl_o), 32'(e.o[2]));
      check("pipeline_flush", i, 32'(bus.pipeline_flush_o), 32'(e.o[1]));
      check("du_stalled", i, 32'(bus.du_stalled_o), 32'(e.o[0]));
      check("seq_state", i, 32'(bus.seq_state_o), 32'(e.s));
      check("stall_cnt", i, bus.stall_cnt_o, want_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
